// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   // Canonical no-op (addi x0, x0, 0) that decode may substitute on a flush.
   localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

   // PC fetched first after reset unless the instance overrides it.
   localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   // One prefetch-queue entry: the instruction tagged with its own PC.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch queue. Flush wins over push and pop;
//                push while full is accepted only together with a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         ENTRY_T = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  ENTRY_T                       wr_data,
   input  logic                         pop,
   input  logic                         flush,
   output ENTRY_T                       rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned c_ptr_w = $clog2(DEPTH);
   localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

   ENTRY_T               r_mem [DEPTH];
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_cnt_w'(DEPTH));
   assign count     = r_count;
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   // Head is read straight out of registered storage; zero while empty.
   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         r_count <= r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
      end
   end

   // Entry storage; contents beyond the occupancy are never observed.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush && !rst) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Decoupled instruction-fetch stage. Issues pipelined requests
//                under a credit limit, tags responses with their PC in a
//                prefetch queue and squashes wrong-path responses on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       N_Bits       = 32,
   parameter int unsigned       FIFO_DEPTH   = 4,
   parameter logic [N_Bits-1:0] RESET_VECTOR = N_Bits'(DEFAULT_RESET_VECTOR)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [N_Bits-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [N_Bits-1:0] imem_rsp_data,
   input  logic              redirect_valid,
   input  logic [N_Bits-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [N_Bits-1:0] instr,
   output logic [N_Bits-1:0] instr_pc
);

   localparam int unsigned       c_cnt_w      = $clog2(FIFO_DEPTH + 1);
   localparam logic [N_Bits-1:0] c_pc_step    = N_Bits'(4);
   localparam logic [N_Bits-1:0] c_align_mask = ~(N_Bits'(3));

   // Same layout as fetch_entry_t, sized to this instance's width.
   typedef struct packed {
      logic [N_Bits-1:0] pc;
      logic [N_Bits-1:0] instr;
   } entry_t;

   logic [N_Bits-1:0]  r_fetch_pc;
   logic [N_Bits-1:0]  r_rsp_pc;
   logic [c_cnt_w-1:0] r_outstanding;
   logic [c_cnt_w-1:0] r_drop_cnt;
   logic [c_cnt_w-1:0] w_fifo_count;
   logic [c_cnt_w:0]   w_credits_used;
   logic [N_Bits-1:0]  w_redirect_target;
   logic               w_req_fire;
   logic               w_rsp_fire;
   logic               w_drop;
   logic               w_push;
   logic               w_pop;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   entry_t             w_push_entry;
   entry_t             w_head;

   // Every issued request reserves a queue slot until its entry leaves, so a
   // response always finds space and the memory never needs backpressure.
   assign w_credits_used    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
   assign imem_req_valid    = ~rst & ~redirect_valid &
                              (w_credits_used < (c_cnt_w + 1)'(FIFO_DEPTH));
   assign imem_req_addr     = r_fetch_pc;
   assign w_req_fire        = imem_req_valid & imem_req_ready;
   assign w_rsp_fire        = imem_rsp_valid;
   assign w_drop            = (r_drop_cnt != '0);
   assign w_redirect_target = redirect_pc & c_align_mask;

   assign w_pop        = instr_valid & instr_ready & ~redirect_valid;
   assign w_push       = w_rsp_fire & ~w_drop & ~redirect_valid & (~w_fifo_full | w_pop);
   assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

   assign instr_valid = ~w_fifo_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

   // Fetch/response PCs, in-flight count and wrong-path squash counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_VECTOR;
         r_rsp_pc      <= RESET_VECTOR;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= r_outstanding + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_fire);
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path; recompute
            // rather than accumulate so back-to-back redirects stay exact.
            r_fetch_pc <= w_redirect_target;
            r_rsp_pc   <= w_redirect_target;
            r_drop_cnt <= r_outstanding - c_cnt_w'(w_rsp_fire);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_pc_step;
            if (w_rsp_fire && w_drop) r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
            if (w_push) r_rsp_pc <= r_rsp_pc + c_pc_step;
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .ENTRY_T (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .wr_data (w_push_entry),
      .pop     (w_pop),
      .flush   (redirect_valid),
      .rd_data (w_head),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .count   (w_fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a variable-latency
//                memory model and a PC/instruction scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
   typedef struct packed { logic [31:0] addr; int due; } pend_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        instr_valid;
   logic        instr_ready    = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   exp_t        sbq[$];
   pend_t       pend[$];
   logic [31:0] popped[$];
   logic [31:0] fire_addrs[$];
   exp_t        mon_e;
   logic [31:0] exp_fetch = '0;
   logic [31:0] held_addr = '0;
   bit          held_v = 1'b0;
   bit          rand_ready = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          lat = 1;
   int          n_holds = 0;

   fetch_unit #(
      .N_Bits       (32),
      .FIFO_DEPTH   (4),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory: one in-order response per accepted request, `lat` cycles later
   initial forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: request address model, stall hold, scoreboard on every pop
   initial forever begin
      @(negedge clk);
      if (rst) begin
         sbq.delete();
         pend.delete();
         exp_fetch = 32'h0000_0000;
         held_v    = 1'b0;
      end else if (redirect_valid) begin
         checks++;
         if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_no_req: imem_req_valid=%b expected 0", imem_req_valid);
         end
         sbq.delete();
         exp_fetch = redirect_pc & 32'hFFFF_FFFC;
         held_v    = 1'b0;
      end else begin
         if (imem_req_valid) begin
            if (held_v) begin
               checks++;
               n_holds++;
               if (imem_req_addr !== held_addr) begin
                  failures++;
                  $display("FAIL addr_hold: addr=%h expected %h", imem_req_addr, held_addr);
               end
            end
            if (imem_req_ready) begin
               checks++;
               if (imem_req_addr !== exp_fetch) begin
                  failures++;
                  $display("FAIL req_addr: addr=%h expected %h", imem_req_addr, exp_fetch);
               end
               sbq.push_back('{pc: exp_fetch, ins: mem_word(exp_fetch)});
               pend.push_back('{addr: imem_req_addr, due: cyc + lat});
               fire_addrs.push_back(imem_req_addr);
               exp_fetch = exp_fetch + 32'd4;
               held_v    = 1'b0;
            end else begin
               held_v    = 1'b1;
               held_addr = imem_req_addr;
            end
         end else begin
            held_v = 1'b0;
         end
         if (instr_valid && instr_ready) begin
            checks++;
            popped.push_back(instr_pc);
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected: instr_pc=%h with no expected entry", instr_pc);
            end else begin
               mon_e = sbq.pop_front();
               if (instr_pc !== mon_e.pc || instr !== mon_e.ins) begin
                  failures++;
                  $display("FAIL pop_order: pc=%h instr=%h expected pc=%h instr=%h",
                           instr_pc, instr, mon_e.pc, mon_e.ins);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
      lat = 1; rand_ready = 1'b0;
      tick(); tick();
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: %b expected 0", imem_req_valid); end
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: %b expected 0", instr_valid); end
      checks++;
      if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: %h expected 0", instr); end
      checks++;
      if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: %h expected 0", instr_pc); end
   endtask

   task automatic test_sequential();
      int c0;
      int first;
      first = -1;
      tick();
      fire_addrs.delete(); popped.delete();
      rst = 1'b0;
      c0  = cyc;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (first < 0 && instr_valid) first = cyc - c0;
      end
      #1;
      checks++;
      if (first !== 2) begin failures++; $display("FAIL seq_first_valid: latency=%0d expected 2", first); end
      checks++;
      if (fire_addrs.size() !== 12) begin failures++; $display("FAIL seq_req_rate: requests=%0d expected 12", fire_addrs.size()); end
      checks++;
      if (popped.size() !== 10) begin failures++; $display("FAIL seq_pop_count: pops=%0d expected 10", popped.size()); end
      else begin
         checks++;
         if (popped[9] !== 32'h24) begin failures++; $display("FAIL seq_pc10: pc=%h expected 00000024", popped[9]); end
      end
   endtask

   task automatic test_stall();
      rst = 1'b1;
      tick(); tick();
      instr_ready = 1'b0;
      fire_addrs.delete(); popped.delete();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (fire_addrs.size() !== 4) begin failures++; $display("FAIL stall_req_count: requests=%0d expected 4", fire_addrs.size()); end
      checks++;
      if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid: %b expected 0", imem_req_valid); end
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
         failures++; $display("FAIL stall_head: valid=%b pc=%h expected 1/00000000", instr_valid, instr_pc);
      end
      tick();
      instr_ready = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks++;
      if (popped.size() < 4) begin failures++; $display("FAIL stall_drain: pops=%0d expected >=4", popped.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (popped[i] !== 32'(i * 4)) begin failures++; $display("FAIL stall_drain_pc: pc=%h expected %h", popped[i], 32'(i * 4)); end
         end
      end
      checks++;
      if (fire_addrs.size() < 5 || fire_addrs[4] !== 32'h10) begin
         failures++; $display("FAIL stall_resume: requests=%0d expected fifth at 00000010", fire_addrs.size());
      end
   endtask

   task automatic test_redirect_latency();
      int old_seen;
      old_seen = 0;
      lat = 3; rst = 1'b1;
      tick(); tick();
      imem_req_ready = 1'b1; instr_ready = 1'b1; rst = 1'b0;
      tick();
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
      popped.delete();
      @(negedge clk);
      checks++;
      if (pend.size() !== 2) begin failures++; $display("FAIL redir_inflight: in_flight=%0d expected 2", pend.size()); end
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      foreach (popped[i]) if (popped[i] < 32'h200) old_seen++;
      checks++;
      if (popped.size() == 0 || popped[0] !== 32'h200) begin
         failures++; $display("FAIL redir_first_pc: pops=%0d expected first pc 00000200", popped.size());
      end
      checks++;
      if (old_seen !== 0) begin failures++; $display("FAIL redir_old_path: old_pcs=%0d expected 0", old_seen); end
   endtask

   task automatic test_double_redirect();
      bit found;
      bit seen;
      int exp_drop;
      int n_rsp;
      found = 1'b0; seen = 1'b0; n_rsp = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (imem_rsp_valid && instr_valid) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL dbl_setup: no response+pop cycle found, found=%b expected 1", found); end
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect_pc = 32'h400;
      exp_drop = pend.size();
      tick();
      redirect_valid = 1'b0;
      popped.delete();
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL dbl_flush: instr_valid=%b expected 0", instr_valid); end
      if (imem_rsp_valid) n_rsp++;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (instr_valid) begin seen = 1'b1; break; end
         if (imem_rsp_valid) n_rsp++;
      end
      checks++;
      if (!seen || n_rsp !== exp_drop + 1) begin
         failures++; $display("FAIL dbl_drop_cnt: responses_before_valid=%0d expected %0d", n_rsp, exp_drop + 1);
      end
      @(negedge clk);
      #1;
      checks++;
      if (popped.size() == 0 || popped[0] !== 32'h400) begin
         failures++; $display("FAIL dbl_first_pc: pops=%0d expected first pc 00000400", popped.size());
      end
   endtask

   task automatic test_misaligned();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect_valid = 1'b0;
      fire_addrs.delete(); popped.delete();
      repeat (12) @(negedge clk);
      #1;
      checks++;
      if (fire_addrs.size() == 0 || fire_addrs[0] !== 32'h100) begin
         failures++; $display("FAIL misalign_req: requests=%0d expected first addr 00000100", fire_addrs.size());
      end
      checks++;
      if (popped.size() == 0 || popped[0] !== 32'h100) begin
         failures++; $display("FAIL misalign_pc: pops=%0d expected first pc 00000100", popped.size());
      end
   endtask

   task automatic test_wrap();
      bit wrapped;
      wrapped = 1'b0;
      lat = 2; rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0; rand_ready = 1'b1; n_holds = 0;
      tick();
      redirect_valid = 1'b0;
      popped.delete();
      repeat (80) @(negedge clk);
      #1;
      for (int i = 0; i + 1 < popped.size(); i++)
         if (popped[i] == 32'hFFFF_FFFC && popped[i+1] == 32'h0) wrapped = 1'b1;
      checks++;
      if (popped.size() == 0 || popped[0] !== 32'hFFFF_FFF0) begin
         failures++; $display("FAIL wrap_first_pc: pops=%0d expected first pc fffffff0", popped.size());
      end
      checks++;
      if (!wrapped) begin failures++; $display("FAIL wrap_pc: wrapped=%b expected 1 (fffffffc then 00000000)", wrapped); end
      checks++;
      if (n_holds == 0) begin failures++; $display("FAIL wrap_stall_seen: holds=%0d expected >0", n_holds); end
      tick();
      rand_ready = 1'b0; imem_req_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_latency();
      test_double_redirect();
      test_misaligned();
      test_wrap();
      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
